// File: rtl/p2s_pkg.sv
// Shared definitions for the AD7864 parallel-to-serial readout sequencer.
// Provides the sequencer state encoding, the tag width and the serial frame
// width helper. The frame width depends on whether P2S_TAG_EN is defined.
package p2s_pkg;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SEL   = 3'd1;
    localparam state_t ST_RD_LO = 3'd2;
    localparam state_t ST_RD_HI = 3'd3;
    localparam state_t ST_SHIFT = 3'd4;
    localparam state_t ST_NEXT  = 3'd5;

    // Serial frame width: raw data word, optionally prefixed by the dev/ch tag.
    function automatic int unsigned p2s_fw(input int unsigned dw, input bit tag_en);
        return tag_en ? dw + TAG_W : dw;
    endfunction

endpackage

// File: rtl/parallel2serial_new_if.sv
// Bundle of the ADC-side, serial-side and status signals of the sequencer.
//   master : sequencer view (enable/db in; cs_bar, rd_bar, spi_*, busy, overrun out)
//   slave  : environment view (ADC bank, DSP port, ad7864Drv)
interface parallel2serial_new_if #(
    parameter int unsigned N_DEV = 4,
    parameter int unsigned DW    = 12
);
    logic             enable;
    logic [DW-1:0]    db;
    logic [N_DEV-1:0] cs_bar;
    logic             rd_bar;
    logic             spi_clk;
    logic             spi_mosi;
    logic             spi_cs_bar;
    logic             busy;
    logic             overrun;

    modport master (
        input  enable, db,
        output cs_bar, rd_bar, spi_clk, spi_mosi, spi_cs_bar, busy, overrun
    );

    modport slave (
        output enable, db,
        input  cs_bar, rd_bar, spi_clk, spi_mosi, spi_cs_bar, busy, overrun
    );
endinterface

// File: rtl/p2s_shifter.sv
// SPI mode-0 word shifter, MSB first.
//   clk, rst_n : clock, async active-low reset
//   load       : one-cycle request to start a frame with 'word'
//   spi_clk    : serial clock, idles low, half period SCLK_HALF cycles
//   spi_mosi   : serial data, changes only on spi_clk falling edges
//   spi_cs_bar : low for the frame, rises one cycle after the last falling edge
//   done       : one-cycle pulse when the frame has ended
module p2s_shifter #(
    parameter int unsigned FW        = 12,
    parameter int unsigned SCLK_HALF = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [FW-1:0] word,
    output logic          spi_clk,
    output logic          spi_mosi,
    output logic          spi_cs_bar,
    output logic          done
);
    localparam int unsigned HC_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned BC_W = $clog2(FW + 1);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_RUN  = 2'd1;
    localparam logic [1:0] PH_END  = 2'd2;

    logic [1:0]      ph_q,   ph_d;
    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic [FW-1:0]   sr_q,   sr_d;
    logic            sclk_q, sclk_d;
    logic            scs_q,  scs_d;
    logic            done_q, done_d;

    // Next-state: half-period counter preloaded so the first rise follows load by one cycle.
    always_comb begin
        ph_d   = ph_q;
        hcnt_d = hcnt_q;
        bcnt_d = bcnt_q;
        sr_d   = sr_q;
        sclk_d = sclk_q;
        scs_d  = scs_q;
        done_d = 1'b0;
        case (ph_q)
            PH_IDLE: begin
                if (load) begin
                    ph_d   = PH_RUN;
                    sr_d   = word;
                    scs_d  = 1'b0;
                    sclk_d = 1'b0;
                    hcnt_d = HC_W'(SCLK_HALF - 1);
                    bcnt_d = '0;
                end
            end
            PH_RUN: begin
                if (hcnt_q == HC_W'(SCLK_HALF - 1)) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end else if (bcnt_q == BC_W'(FW)) begin
                        ph_d = PH_END;
                    end else begin
                        sr_d = sr_q << 1;
                    end
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            PH_END: begin
                scs_d  = 1'b1;
                done_d = 1'b1;
                ph_d   = PH_IDLE;
            end
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= PH_IDLE;
            hcnt_q <= '0;
            bcnt_q <= '0;
            sr_q   <= '0;
            sclk_q <= 1'b0;
            scs_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            hcnt_q <= hcnt_d;
            bcnt_q <= bcnt_d;
            sr_q   <= sr_d;
            sclk_q <= sclk_d;
            scs_q  <= scs_d;
            done_q <= done_d;
        end
    end

    assign spi_clk    = sclk_q;
    assign spi_mosi   = sr_q[FW-1];
    assign spi_cs_bar = scs_q;
    assign done       = done_q;

endmodule

// File: rtl/parallel2serial_new.sv
// AD7864 bank readout sequencer: on a db_rdy rising edge reads every channel of
// every device over the shared parallel bus and shifts each word out over SPI.
//   clkin   : clock
//   rst_bar : async active-low reset
//   bus     : enable/db in; cs_bar, rd_bar, spi_clk, spi_mosi, spi_cs_bar, busy, overrun out
// Build option: P2S_TAG_EN prefixes each serial word with {dev[1:0], ch[1:0]}.
module parallel2serial_new
    import p2s_pkg::*;
#(
    parameter int unsigned N_DEV     = 4,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DW        = 12,
    parameter int unsigned RD_LO_CYC = 2,
    parameter int unsigned RD_HI_CYC = 2,
    parameter int unsigned SCLK_HALF = 1
) (
    input  logic                  clkin,
    input  logic                  rst_bar,
    parallel2serial_new_if.master bus
);
`ifdef P2S_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif
    localparam int unsigned FW      = p2s_fw(DW, TAG_EN);
    localparam int unsigned DEV_W   = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_MAX = (RD_LO_CYC > RD_HI_CYC) ? RD_LO_CYC : RD_HI_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       en_sync_q;
    state_t           state_q,   state_d;
    logic [DEV_W-1:0] dev_q,     dev_d;
    logic [CH_W-1:0]  ch_q,      ch_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [FW-1:0]    word_q,    word_d;
    logic [N_DEV-1:0] cs_bar_q,  cs_bar_d;
    logic             rd_bar_q,  rd_bar_d;
    logic             busy_q,    busy_d;
    logic             overrun_q, overrun_d;
    logic             load_q,    load_d;
    logic             en_rise_c;
    logic             shift_done_c;
    logic [N_DEV-1:0] cs_sel_c;
    logic [FW-1:0]    cap_c;

    // Two synchronizer stages plus one history flop for edge detection.
    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) en_sync_q <= '0;
        else          en_sync_q <= {en_sync_q[1:0], bus.enable};
    end

    assign en_rise_c = en_sync_q[1] & ~en_sync_q[2];
    assign cs_sel_c  = ~(N_DEV'(1) << dev_q);

`ifdef P2S_TAG_EN
    assign cap_c = {2'(dev_q), 2'(ch_q), bus.db};
`else
    assign cap_c = bus.db;
`endif

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        dev_d     = dev_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        cs_bar_d  = cs_bar_q;
        rd_bar_d  = rd_bar_q;
        busy_d    = busy_q;
        load_d    = 1'b0;
        overrun_d = overrun_q | (en_rise_c & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (en_rise_c) begin
                    state_d  = ST_SEL;
                    dev_d    = '0;
                    ch_d     = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    cs_bar_d = ~N_DEV'(1);
                end
            end
            ST_SEL: begin
                // After a device change cs_bar is still all-high: select first, then time the setup.
                cs_bar_d = cs_sel_c;
                if (!(&cs_bar_q)) begin
                    if (cnt_q == CNT_W'(RD_HI_CYC - 1)) begin
                        state_d  = ST_RD_LO;
                        rd_bar_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RD_LO: begin
                if (cnt_q == CNT_W'(RD_LO_CYC - 1)) begin
                    state_d  = ST_RD_HI;
                    word_d   = cap_c;
                    rd_bar_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_HI: begin
                if (cnt_q == CNT_W'(RD_HI_CYC - 1)) begin
                    state_d = ST_SHIFT;
                    load_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift_done_c) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (ch_q != CH_W'(N_CH - 1)) begin
                    state_d  = ST_RD_LO;
                    ch_d     = ch_q + CH_W'(1);
                    rd_bar_d = 1'b0;
                    cnt_d    = '0;
                end else if (dev_q != DEV_W'(N_DEV - 1)) begin
                    state_d  = ST_SEL;
                    dev_d    = dev_q + DEV_W'(1);
                    ch_d     = '0;
                    cnt_d    = '0;
                    cs_bar_d = '1;
                end else begin
                    state_d  = ST_IDLE;
                    dev_d    = '0;
                    ch_d     = '0;
                    cnt_d    = '0;
                    cs_bar_d = '1;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            state_q   <= ST_IDLE;
            dev_q     <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            cs_bar_q  <= '1;
            rd_bar_q  <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dev_q     <= dev_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            cs_bar_q  <= cs_bar_d;
            rd_bar_q  <= rd_bar_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            load_q    <= load_d;
        end
    end

    p2s_shifter #(
        .FW        (FW),
        .SCLK_HALF (SCLK_HALF)
    ) u_shifter (
        .clk        (clkin),
        .rst_n      (rst_bar),
        .load       (load_q),
        .word       (word_q),
        .spi_clk    (bus.spi_clk),
        .spi_mosi   (bus.spi_mosi),
        .spi_cs_bar (bus.spi_cs_bar),
        .done       (shift_done_c)
    );

    assign bus.cs_bar  = cs_bar_q;
    assign bus.rd_bar  = rd_bar_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_parallel2serial_new.sv
// Self-checking bench for parallel2serial_new: drives db_rdy pulses and ADC bus
// data, reassembles serial frames and compares them against words computed from
// the data presented on each read and the dev/ch read order.
module tb_parallel2serial_new;
    localparam int unsigned N_DEV = 4;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned DW    = 12;
    localparam int unsigned NW    = N_DEV * N_CH;
`ifdef P2S_TAG_EN
    localparam bit          TAG = 1'b1;
    localparam int unsigned FW  = DW + 4;
`else
    localparam bit          TAG = 1'b0;
    localparam int unsigned FW  = DW;
`endif
    localparam logic [N_DEV+5:0] RST_VEC = {{N_DEV{1'b1}}, 6'b100100};
    localparam int BOUND = 8000;

    logic clkin   = 1'b0;
    logic rst_bar = 1'b0;
    always #5 clkin = ~clkin;

    parallel2serial_new_if #(.N_DEV(N_DEV), .DW(DW)) bus ();

    parallel2serial_new dut (
        .clkin   (clkin),
        .rst_bar (rst_bar),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Monitor controls (written by tests only).
    int            clr_req = 0;
    int            db_mode = 0;   // 0 constant, 1 increment per read, 2 random per read
    logic [DW-1:0] db_base = '0;

    // Monitor state (written by the monitor only).
    int          clr_seen = 0;
    int          fr_w[$];
    int          fr_n[$];
    int          rd_db[$];
    int          cs_seq[$];
    int          rd_falls = 0, rd_rises = 0, viol = 0, busy_falls = 0, frames_at_fall = -1;
    logic [31:0] sh = '0;
    int          nb = 0;
    logic        rd_p = 1'b1, sclk_p = 1'b0, scs_p = 1'b1, mosi_p = 1'b0, busy_p = 1'b0;

    // Expected serial word for read index k carrying ADC data d.
    function automatic int exp_word(input int k, input int d);
        int w;
        w = d & ((1 << DW) - 1);
        if (TAG) w = ((k / N_CH) << (DW + 2)) | ((k % N_CH) << DW) | w;
        return w;
    endfunction

    function automatic logic [N_DEV+5:0] outs_now();
        return {bus.cs_bar, bus.rd_bar, bus.spi_clk, bus.spi_mosi, bus.spi_cs_bar, bus.busy, bus.overrun};
    endfunction

    // Bus monitor and ADC data model, sampled on the falling clock edge.
    always @(negedge clkin) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            fr_w.delete(); fr_n.delete(); rd_db.delete(); cs_seq.delete();
            rd_falls = 0; rd_rises = 0; viol = 0; busy_falls = 0; frames_at_fall = -1;
            sh = '0; nb = 0;
            bus.db = db_base;
        end
        if (rd_p && !bus.rd_bar) begin
            rd_falls++;
            rd_db.push_back(int'(bus.db));
            cs_seq.push_back(int'(bus.cs_bar));
        end
        if (!rd_p && bus.rd_bar) begin
            rd_rises++;
            if (db_mode == 1)      bus.db = bus.db + DW'(1);
            else if (db_mode == 2) bus.db = DW'($urandom);
        end
        if (!scs_p && !bus.spi_cs_bar) begin
            if (!sclk_p && bus.spi_clk) begin
                sh = {sh[30:0], bus.spi_mosi};
                nb++;
            end
            if ((bus.spi_mosi != mosi_p) && !(sclk_p && !bus.spi_clk)) viol++;
        end
        if (!scs_p && bus.spi_cs_bar) begin
            fr_w.push_back(int'(sh));
            fr_n.push_back(nb);
            if (bus.spi_clk) viol++;
            sh = '0;
            nb = 0;
        end
        if (busy_p && !bus.busy) begin
            busy_falls++;
            frames_at_fall = fr_w.size();
        end
        rd_p   = bus.rd_bar;
        sclk_p = bus.spi_clk;
        scs_p  = bus.spi_cs_bar;
        mosi_p = bus.spi_mosi;
        busy_p = bus.busy;
    end

    task automatic clear_mon(input int mode, input logic [DW-1:0] base);
        db_mode = mode;
        db_base = base;
        clr_req++;
        repeat (2) @(negedge clkin);
    endtask

    task automatic pulse_enable();
        @(negedge clkin);
        #2 bus.enable = 1'b1;
        repeat (4) @(negedge clkin);
        bus.enable = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy_falls == 0 && n < BOUND) begin
            @(negedge clkin);
            n++;
        end
        ok = (busy_falls != 0);
    endtask

    task automatic do_reset();
        rst_bar = 1'b0;
        repeat (3) @(negedge clkin);
        rst_bar = 1'b1;
        repeat (2) @(negedge clkin);
    endtask

    task automatic test_reset();
        int bad = 0;
        bus.enable = 1'b0;
        rst_bar    = 1'b0;
        repeat (3) @(negedge clkin);
        checks++;
        if (outs_now() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold outs=%b required=%b", outs_now(), RST_VEC);
        end
        rst_bar = 1'b1;
        repeat (1000) begin
            @(negedge clkin);
            if (outs_now() !== RST_VEC) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle cycles_off_reset=%0d required=0", bad);
        end
    endtask

    task automatic test_const();
        bit ok;
        int bad = 0;
        clear_mon(0, 12'h5D2);
        pulse_enable();
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL const_timeout busy_falls=0 required=1"); end
        checks++;
        if (fr_w.size() != NW) begin errors++; $display("FAIL const_frames got=%0d required=%0d", fr_w.size(), NW); end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (fr_w[k] !== exp_word(k, 'h5D2) || fr_n[k] !== FW) begin
                errors++;
                $display("FAIL const_word[%0d] got=%h/%0d bits required=%h/%0d bits", k, fr_w[k], fr_n[k], exp_word(k, 'h5D2), FW);
            end
        end
        checks++;
        if (rd_falls != NW || rd_rises != NW) begin
            errors++; $display("FAIL const_rd_pulses falls=%0d rises=%0d required=%0d", rd_falls, rd_rises, NW);
        end
        for (int k = 0; k < NW; k++) begin
            if (cs_seq[k] !== (~(1 << (k / N_CH)) & ((1 << N_DEV) - 1))) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL const_cs_seq bad_reads=%0d required=0 first=%h", bad, cs_seq[0]); end
        checks++;
        if (frames_at_fall != NW) begin errors++; $display("FAIL const_busy_fall frames_at_fall=%0d required=%0d", frames_at_fall, NW); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL const_spi_protocol violations=%0d required=0", viol); end
    endtask

    task automatic test_incr();
        bit ok;
        int bad = 0;
        clear_mon(1, 12'h000);
        pulse_enable();
        wait_idle(ok);
        checks++;
        if (!ok || fr_w.size() != NW) begin errors++; $display("FAIL incr_frames got=%0d required=%0d", fr_w.size(), NW); end
        for (int k = 0; k < NW; k++) if (fr_w[k] !== exp_word(k, k)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL incr_words bad=%0d required=0 first=%h last=%h", bad, fr_w[0], fr_w[NW-1]); end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 3; it++) begin
            int bad = 0;
            clear_mon(2, DW'($urandom));
            pulse_enable();
            wait_idle(ok);
            checks++;
            if (!ok || fr_w.size() != NW || rd_db.size() != NW) begin
                errors++; $display("FAIL rand%0d_counts frames=%0d reads=%0d required=%0d", it, fr_w.size(), rd_db.size(), NW);
            end
            for (int k = 0; k < NW; k++) if (fr_w[k] !== exp_word(k, rd_db[k])) bad++;
            checks++;
            if (bad != 0 || viol != 0) begin
                errors++; $display("FAIL rand%0d_words bad=%0d viol=%0d required=0", it, bad, viol);
            end
        end
    endtask

    task automatic test_tag();
        bit ok;
        int e0, e11;
`ifdef P2S_TAG_EN
        e0 = 'h0ABC; e11 = 'hBABC;
`else
        e0 = 'hABC;  e11 = 'hABC;
`endif
        clear_mon(0, 12'hABC);
        pulse_enable();
        wait_idle(ok);
        checks++;
        if (!ok || fr_w[0] !== e0) begin errors++; $display("FAIL tag_first got=%h required=%h", fr_w[0], e0); end
        checks++;
        if (fr_w[11] !== e11) begin errors++; $display("FAIL tag_dev2_ch3 got=%h required=%h", fr_w[11], e11); end
    endtask

    task automatic test_overrun();
        bit ok;
        int bad = 0;
        do_reset();
        checks++;
        if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b required=0", bus.overrun); end
        clear_mon(1, 12'h000);
        pulse_enable();
        repeat (150) @(negedge clkin);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL ovr_busy_mid got=%b required=1", bus.busy); end
        pulse_enable();
        repeat (10) @(negedge clkin);
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b required=1", bus.overrun); end
        wait_idle(ok);
        for (int k = 0; k < NW; k++) if (fr_w[k] !== exp_word(k, k)) bad++;
        checks++;
        if (!ok || fr_w.size() != NW || bad != 0) begin
            errors++; $display("FAIL ovr_sequence frames=%0d bad=%0d required=%0d/0", fr_w.size(), bad, NW);
        end
        repeat (50) @(negedge clkin);
        checks++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_after busy=%b overrun=%b required=0/1", bus.busy, bus.overrun);
        end
        clear_mon(1, 12'h000);
        pulse_enable();
        wait_idle(ok);
        checks++;
        if (!ok || fr_w.size() != NW || bus.overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_restart frames=%0d overrun=%b required=%0d/1", fr_w.size(), bus.overrun, NW);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int bad = 0;
        clear_mon(1, 12'h000);
        pulse_enable();
        while (!(fr_w.size() == 4 && bus.spi_cs_bar === 1'b0) && n < BOUND) begin
            @(negedge clkin);
            n++;
        end
        checks++;
        if (n >= BOUND) begin errors++; $display("FAIL rstmid_reach_word5 frames=%0d required=4", fr_w.size()); end
        repeat (5) @(negedge clkin);
        #2 rst_bar = 1'b0;
        #1;
        checks++;
        if (outs_now() !== RST_VEC) begin errors++; $display("FAIL rstmid_async outs=%b required=%b", outs_now(), RST_VEC); end
        repeat (3) @(negedge clkin);
        rst_bar = 1'b1;
        repeat (2) @(negedge clkin);
        clear_mon(1, 12'h000);
        pulse_enable();
        wait_idle(ok);
        for (int k = 0; k < NW; k++) if (fr_w[k] !== exp_word(k, k)) bad++;
        checks++;
        if (!ok || fr_w.size() != NW || fr_w[0] !== exp_word(0, 0) || cs_seq[0] !== 'hE) begin
            errors++; $display("FAIL rstmid_restart frames=%0d first=%h cs0=%h required=%0d/%h/e", fr_w.size(), fr_w[0], cs_seq[0], NW, exp_word(0, 0));
        end
        checks++;
        if (bad != 0 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL rstmid_words bad=%0d overrun=%b required=0/0", bad, bus.overrun);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        test_reset();
        test_const();
        test_incr();
        test_random();
        test_tag();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
